seven_seg_scanner: RTL

Time-multiplexing controller that shares one combinational BCD-to-7-segment decoder among NDIG common-anode digits. Each cycle it drives the decoder with the BCD code of the active digit and enables that digit's anode. It inserts a dead-time blanking gap between digits, and can suppress leading zeros. Displayed data is double-buffered and swapped only at frame boundaries, so a multi-digit update never tears. It sits between the application logic (counters, measurement results) and the board's display pins.

---
 rtl/seven_seg_scanner.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scanner that feeds one shared BCD-to-7-segment decoder and drives NDIG
// common-anode digits. It adds a blanking gap at the start of each slot, optional
// leading-zero suppression, and display data that changes only at frame boundaries.
module seven_seg_scanner #(
  parameter int NDIG         = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              lz_blank,
  output logic [3:0]        bcd_out,
  output logic              dp_n,
  output logic [NDIG-1:0]   anode_n,
  output logic              frame_done
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } phase_e;

  phase_e                 phase_q, phase_d;
  logic                   run_q, run_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]          dig_q, dig_d;
  logic [NDIG-1:0][3:0]   pend_bcd_q, pend_bcd_d;
  logic [NDIG-1:0]        pend_dp_q, pend_dp_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [NDIG-1:0][3:0]   disp_bcd_q, disp_bcd_d;
  logic [NDIG-1:0]        disp_dp_q, disp_dp_d;
  logic [3:0]             bcd_out_q, bcd_out_d;
  logic                   dp_n_q, dp_n_d;
  logic [NDIG-1:0]        anode_n_q, anode_n_d;
  logic                   frame_done_q, frame_done_d;

  logic                   boundary;
  logic                   zero_above;
  logic [NDIG-1:0]        supp;
  logic                   lit;

  // Slot/digit sequencing and buffer management.
  always_comb begin
    run_d        = run_q;
    cnt_d        = cnt_q;
    dig_d        = dig_q;
    pend_bcd_d   = pend_bcd_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_bcd_d   = disp_bcd_q;
    disp_dp_d    = disp_dp_q;
    frame_done_d = 1'b0;
    boundary     = 1'b0;

    if (!en) begin
      run_d        = 1'b0;
      cnt_d        = '0;
      dig_d        = '0;
      pend_valid_d = 1'b0;
      if (load) begin
        disp_bcd_d = bcd_in;
        disp_dp_d  = dp_in;
      end else if (pend_valid_q) begin
        disp_bcd_d = pend_bcd_q;
        disp_dp_d  = pend_dp_q;
      end
    end else begin
      run_d = 1'b1;
      // The first enabled edge after idle is itself a frame start.
      if (!run_q) begin
        cnt_d    = '0;
        dig_d    = '0;
        boundary = 1'b1;
      end else if (cnt_q == CW'(TICK_DIV - 1)) begin
        cnt_d = '0;
        if (dig_q == DW'(NDIG - 1)) begin
          dig_d    = '0;
          boundary = 1'b1;
        end else begin
          dig_d = dig_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      if (boundary) begin
        frame_done_d = 1'b1;
        pend_valid_d = 1'b0;
        if (load) begin
          disp_bcd_d = bcd_in;
          disp_dp_d  = dp_in;
        end else if (pend_valid_q) begin
          disp_bcd_d = pend_bcd_q;
          disp_dp_d  = pend_dp_q;
        end
      end else if (load) begin
        pend_bcd_d   = bcd_in;
        pend_dp_d    = dp_in;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Phase FSM next state follows the slot counter position.
  always_comb begin
    phase_d = (cnt_d >= CW'(BLANK_CYCLES)) ? SHOW : BLANK;
  end

  // Digit i>0 is suppressed when it and every more significant digit are zero.
  always_comb begin
    zero_above = lz_blank;
    supp       = '0;
    for (int i = NDIG - 1; i > 0; i--) begin
      zero_above = zero_above & (disp_bcd_d[i] == 4'd0);
      supp[i]    = zero_above;
    end
  end

  // Outputs are registered from next-state values so they line up with cnt/dig.
  always_comb begin
    lit       = run_d && (phase_d == SHOW) && !supp[dig_d];
    bcd_out_d = disp_bcd_d[dig_d];
    anode_n_d = '1;
    if (lit) begin
      anode_n_d[dig_d] = 1'b0;
    end
    dp_n_d = !(lit && disp_dp_d[dig_d]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= BLANK;
      run_q        <= 1'b0;
      cnt_q        <= '0;
      dig_q        <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
      bcd_out_q    <= 4'd0;
      dp_n_q       <= 1'b1;
      anode_n_q    <= '1;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      run_q        <= run_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
      bcd_out_q    <= bcd_out_d;
      dp_n_q       <= dp_n_d;
      anode_n_q    <= anode_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd_out    = bcd_out_q;
  assign dp_n       = dp_n_q;
  assign anode_n    = anode_n_q;
  assign frame_done = frame_done_q;

endmodule
